// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode and
// function constants, datapath select codes, decoded instruction classes and the
// packed control-strobe bundle driven toward the datapath.
package mc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
  localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b011;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;

  localparam logic [1:0] WD_ALU    = 2'b00;
  localparam logic [1:0] WD_MEM    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JAL, C_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
  } ctl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bus.
//   instr, mem_ready, zero : datapath status into the controller
//   pc_write .. wd_sel      : control strobes/selects out of the controller
// master = controller side, slave = datapath side.
interface mc_ctrl_if;

  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic [1:0]  ext_op;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;

  modport master (
    input  instr, mem_ready, zero,
    output pc_write, ir_write, reg_write, mem_read, mem_write,
           pc_src, alu_op, alu_src, ext_op, reg_dst, wd_sel
  );

  modport slave (
    output instr, mem_ready, zero,
    input  pc_write, ir_write, reg_write, mem_read, mem_write,
           pc_src, alu_op, alu_src, ext_op, reg_dst, wd_sel
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
//   instr   : IR contents
//   iclass  : decoded instruction class (C_ILLEGAL for anything unsupported)
//   illegal : 1 when the op/func pair is outside the supported set
module mc_decode
  import mc_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output instr_class_e       iclass,
  output logic               illegal
);

  logic [OP_W-1:0] op;
  logic [OP_W-1:0] fn;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  // An all-zero word is the canonical nop and wins over the R-type func decode.
  always_comb begin
    iclass = C_ILLEGAL;
    if (instr == '0) begin
      iclass = C_NOP;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_ADDU: iclass = C_ADDU;
            FN_SUBU: iclass = C_SUBU;
            FN_JR:   iclass = C_JR;
            default: iclass = C_ILLEGAL;
          endcase
        end
        OP_ORI:  iclass = C_ORI;
        OP_LUI:  iclass = C_LUI;
        OP_LW:   iclass = C_LW;
        OP_SW:   iclass = C_SW;
        OP_BEQ:  iclass = C_BEQ;
        OP_BNE:  iclass = C_BNE;
        OP_J:    iclass = C_J;
        OP_JAL:  iclass = C_JAL;
        default: iclass = C_ILLEGAL;
      endcase
    end
  end

  assign illegal = (iclass == C_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky
// TRAP state, datapath strobes decoded from state plus instruction, and
// saturating cycle / retired-instruction counters.
//   clk, reset   : clock, synchronous active-low reset
//   bus          : controller side of the datapath bus
//   state        : current state encoding
//   trap         : 1 while in TRAP
//   instr_done   : 1-cycle pulse on each entry into FETCH from another state
//   cycle_cnt    : non-reset cycles seen (saturating)
//   instr_cnt    : retired instructions (saturating)
module mc_ctrl
  import mc_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  mc_ctrl_if.master        bus,
  output logic [2:0]       state,
  output logic             trap,
  output logic             instr_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e       cur;
  state_e       nxt;
  ctl_t         ctl;
  instr_class_e iclass;
  logic         illegal;
  logic         mem_ok;
  logic         retire;

  mc_decode u_decode (
    .instr   (bus.instr),
    .iclass  (iclass),
    .illegal (illegal)
  );

  assign mem_ok = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign retire = (nxt == S_FETCH) && (cur != S_FETCH);

  // Next state and strobe decode; strobes are forced low while reset is held.
  always_comb begin
    nxt = cur;
    ctl = '0;
    if (reset) begin
      case (cur)
        S_FETCH: begin
          ctl.mem_read = 1'b1;
          if (mem_ok) begin
            ctl.ir_write = 1'b1;
            ctl.pc_write = 1'b1;
            ctl.pc_src   = PC_PLUS4;
            nxt          = S_DECODE;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            nxt = S_TRAP;
          end else begin
            case (iclass)
              C_NOP: nxt = S_FETCH;
              C_J: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PC_JUMP;
                nxt          = S_FETCH;
              end
              C_JAL: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_src    = PC_JUMP;
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = DST_RA;
                ctl.wd_sel    = WD_PC;
                nxt           = S_FETCH;
              end
              default: nxt = S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          case (iclass)
            C_ADDU: begin
              ctl.alu_op = ALU_ADD;
              nxt        = S_WB;
            end
            C_SUBU: begin
              ctl.alu_op = ALU_SUB;
              nxt        = S_WB;
            end
            C_ORI: begin
              ctl.alu_op  = ALU_OR;
              ctl.alu_src = 1'b1;
              ctl.ext_op  = EXT_ZERO;
              nxt         = S_WB;
            end
            C_LUI: begin
              ctl.alu_op  = ALU_LUI;
              ctl.alu_src = 1'b1;
              ctl.ext_op  = EXT_UPPER;
              nxt         = S_WB;
            end
            C_LW, C_SW: begin
              ctl.alu_op  = ALU_ADD;
              ctl.alu_src = 1'b1;
              ctl.ext_op  = EXT_SIGN;
              nxt         = S_MEM;
            end
            C_BEQ: begin
              ctl.pc_write = bus.zero;
              ctl.pc_src   = PC_BRANCH;
              nxt          = S_FETCH;
            end
            C_BNE: begin
              ctl.pc_write = ~bus.zero;
              ctl.pc_src   = PC_BRANCH;
              nxt          = S_FETCH;
            end
            C_JR: begin
              ctl.pc_write = 1'b1;
              ctl.pc_src   = PC_REG;
              nxt          = S_FETCH;
            end
            // IR changed under an in-flight instruction: treat as a fault.
            default: nxt = S_TRAP;
          endcase
        end
        S_MEM: begin
          if (iclass == C_SW) ctl.mem_write = 1'b1;
          else                ctl.mem_read  = 1'b1;
          if (mem_ok) nxt = (iclass == C_SW) ? S_FETCH : S_WB;
        end
        S_WB: begin
          ctl.reg_write = 1'b1;
          ctl.reg_dst   = (iclass == C_ADDU || iclass == C_SUBU) ? DST_RD : DST_RT;
          ctl.wd_sel    = (iclass == C_LW) ? WD_MEM : WD_ALU;
          nxt           = S_FETCH;
        end
        S_TRAP:  nxt = S_TRAP;
        default: nxt = S_TRAP;
      endcase
    end
  end

  // State, status flags and saturating counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur        <= S_FETCH;
      trap       <= 1'b0;
      instr_done <= 1'b0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      cur        <= nxt;
      trap       <= (nxt == S_TRAP);
      instr_done <= retire;
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire && instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign state         = cur;
  assign bus.pc_write  = ctl.pc_write;
  assign bus.ir_write  = ctl.ir_write;
  assign bus.reg_write = ctl.reg_write;
  assign bus.mem_read  = ctl.mem_read;
  assign bus.mem_write = ctl.mem_write;
  assign bus.pc_src    = ctl.pc_src;
  assign bus.alu_op    = ctl.alu_op;
  assign bus.alu_src   = ctl.alu_src;
  assign bus.ext_op    = ctl.ext_op;
  assign bus.reg_dst   = ctl.reg_dst;
  assign bus.wd_sel    = ctl.wd_sel;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed per-cycle vectors push expected
// outputs into a queue; a negedge monitor pops and compares. A second,
// narrow-counter instance without memory handshake runs back-to-back nops.
module tb_mc_ctrl;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_T = 3'd7;

  // strobe order: pc_write, ir_write, reg_write, mem_read, mem_write
  localparam logic [4:0] PCW = 5'b10000;
  localparam logic [4:0] IRW = 5'b01000;
  localparam logic [4:0] RGW = 5'b00100;
  localparam logic [4:0] MRD = 5'b00010;
  localparam logic [4:0] MWR = 5'b00001;
  localparam logic [4:0] FE  = 5'b11010;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_SUBU = 32'h0022_1823;
  localparam logic [31:0] I_ORI  = 32'h3422_1234;
  localparam logic [31:0] I_LUI  = 32'h3C02_5678;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0008;
  localparam logic [31:0] I_BEQ  = 32'h1022_0004;
  localparam logic [31:0] I_BNE  = 32'h1422_0004;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;

  logic clk = 1'b0;
  logic reset;
  logic reset_s;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();
  mc_ctrl_if bus_s ();

  logic [2:0]  state, state_s;
  logic        trap, trap_s, instr_done, instr_done_s;
  logic [31:0] cycle_cnt, instr_cnt;
  logic [3:0]  cycle_cnt_s, instr_cnt_s;

  mc_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .state      (state),
    .trap       (trap),
    .instr_done (instr_done),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  mc_ctrl #(.MEM_HANDSHAKE(1'b0), .CNT_W(4)) u_sat (
    .clk        (clk),
    .reset      (reset_s),
    .bus        (bus_s),
    .state      (state_s),
    .trap       (trap_s),
    .instr_done (instr_done_s),
    .cycle_cnt  (cycle_cnt_s),
    .instr_cnt  (instr_cnt_s)
  );

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [4:0]  stb;
    logic [1:0]  ps;
    logic [2:0]  aop;
    logic        asrc;
    logic [1:0]  ext;
    logic [1:0]  rdst;
    logic [1:0]  wds;
    logic        trp;
    logic        done;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  typedef struct {
    int         k;
    logic [2:0] st;
    logic [3:0] cc;
    logic [3:0] ic;
  } sexp_t;

  exp_t  q[$];
  sexp_t sq[$];

  int   n_vec = 0;
  int   n_bad = 0;
  logic end_req = 1'b0;
  logic end_seen = 1'b0;
  logic sat_done = 1'b0;

  logic        prev_rst = 1'b0;
  logic [31:0] exp_cc = '0;
  logic [31:0] exp_ic = '0;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input string tag, input logic rst, input logic rdy, input logic z,
                     input logic [2:0] st, input logic [4:0] stb, input logic [1:0] ps,
                     input logic [2:0] aop, input logic asrc, input logic [1:0] ext,
                     input logic [1:0] rdst, input logic [1:0] wds, input logic done);
    exp_t e;
    if (!prev_rst) begin
      exp_cc = '0;
      exp_ic = '0;
    end else begin
      if (exp_cc != 32'hFFFF_FFFF) exp_cc = exp_cc + 32'd1;
      if (done) exp_ic = exp_ic + 32'd1;
    end
    reset         = rst;
    bus.mem_ready = rdy;
    bus.zero      = z;
    e.tag = tag; e.st = st; e.stb = stb; e.ps = ps; e.aop = aop; e.asrc = asrc;
    e.ext = ext; e.rdst = rdst; e.wds = wds; e.trp = (st == ST_T); e.done = done;
    e.ic = exp_ic; e.cc = exp_cc;
    q.push_back(e);
    prev_rst = rst;
    @(posedge clk);
    #1;
  endtask

  // Shorthands for the common cycle shapes.
  task automatic fetch(input string tag, input logic rdy, input logic done);
    cyc(tag, 1'b1, rdy, 1'b0, ST_F, rdy ? FE : MRD, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, done);
  endtask

  task automatic quiet(input string tag, input logic [2:0] st);
    cyc(tag, 1'b1, 1'b0, 1'b0, st, 5'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic exec_alu(input string tag, input logic [2:0] aop, input logic asrc, input logic [1:0] ext);
    cyc(tag, 1'b1, 1'b1, 1'b0, ST_E, 5'b0, 2'b00, aop, asrc, ext, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic wb(input string tag, input logic [1:0] rdst, input logic [1:0] wds);
    cyc(tag, 1'b1, 1'b1, 1'b0, ST_W, RGW, 2'b00, 3'b000, 1'b0, 2'b00, rdst, wds, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t       e;
    sexp_t      s;
    logic [4:0] a_stb;
    if (q.size() > 0) begin
      e = q.pop_front();
      a_stb = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write};
      n_vec++;
      if (state !== e.st || a_stb !== e.stb || bus.pc_src !== e.ps || bus.alu_op !== e.aop ||
          bus.alu_src !== e.asrc || bus.ext_op !== e.ext || bus.reg_dst !== e.rdst ||
          bus.wd_sel !== e.wds || trap !== e.trp || instr_done !== e.done ||
          instr_cnt !== e.ic || cycle_cnt !== e.cc) begin
        n_bad++;
        $display("FAIL %s: got st=%0d stb=%b ps=%b alu=%b src=%b ext=%b dst=%b wd=%b trap=%b done=%b ic=%0d cc=%0d | want st=%0d stb=%b ps=%b alu=%b src=%b ext=%b dst=%b wd=%b trap=%b done=%b ic=%0d cc=%0d",
                 e.tag, state, a_stb, bus.pc_src, bus.alu_op, bus.alu_src, bus.ext_op,
                 bus.reg_dst, bus.wd_sel, trap, instr_done, instr_cnt, cycle_cnt,
                 e.st, e.stb, e.ps, e.aop, e.asrc, e.ext, e.rdst, e.wds, e.trp, e.done, e.ic, e.cc);
      end
    end
    if (sq.size() > 0) begin
      s = sq.pop_front();
      n_vec++;
      if (state_s !== s.st || cycle_cnt_s !== s.cc || instr_cnt_s !== s.ic) begin
        n_bad++;
        $display("FAIL sat_nop[%0d]: got st=%0d cc=%0d ic=%0d | want st=%0d cc=%0d ic=%0d",
                 s.k, state_s, cycle_cnt_s, instr_cnt_s, s.st, s.cc, s.ic);
      end
    end
    if (end_req && !end_seen) begin
      n_vec++;
      if (q.size() != 0 || sq.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d/%0d pending | want 0/0", q.size(), sq.size());
      end
      end_seen <= 1'b1;
    end
  end

  // Narrow counters, no handshake: a stream of nops with mem_ready held low.
  initial begin : sat_stim
    sexp_t s;
    reset_s = 1'b0;
    bus_s.instr = I_NOP;
    bus_s.mem_ready = 1'b0;
    bus_s.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s.k = -1; s.st = ST_F; s.cc = 4'd0; s.ic = 4'd0;
    sq.push_back(s);
    @(posedge clk);
    #1;
    reset_s = 1'b1;
    for (int k = 0; k < 44; k++) begin
      s.k  = k;
      s.st = (k % 2 == 1) ? ST_D : ST_F;
      s.cc = (k > 15) ? 4'd15 : 4'(k);
      s.ic = (k / 2 > 15) ? 4'd15 : 4'(k / 2);
      sq.push_back(s);
      @(posedge clk);
      #1;
    end
    sat_done = 1'b1;
  end

  initial begin : main_stim
    reset = 1'b0;
    bus.instr = I_NOP;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // held in reset: strobes low even with memory ready
    cyc("rst_hold", 1'b0, 1'b1, 1'b0, ST_F, 5'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    bus.instr = I_ADDU;
    fetch("addu_F", 1'b1, 1'b0);
    quiet("addu_D", ST_D);
    exec_alu("addu_E", 3'b000, 1'b0, 2'b00);
    wb("addu_W", 2'b01, 2'b00);

    bus.instr = I_SUBU;
    fetch("subu_F", 1'b1, 1'b1);
    quiet("subu_D", ST_D);
    exec_alu("subu_E", 3'b001, 1'b0, 2'b00);
    wb("subu_W", 2'b01, 2'b00);

    bus.instr = I_ORI;
    fetch("ori_F", 1'b1, 1'b1);
    quiet("ori_D", ST_D);
    exec_alu("ori_E", 3'b010, 1'b1, 2'b00);
    wb("ori_W", 2'b00, 2'b00);

    bus.instr = I_LUI;
    fetch("lui_F", 1'b1, 1'b1);
    quiet("lui_D", ST_D);
    exec_alu("lui_E", 3'b011, 1'b1, 2'b10);
    wb("lui_W", 2'b00, 2'b00);

    bus.instr = I_LW;
    fetch("lw_Fwait", 1'b0, 1'b1);
    fetch("lw_F", 1'b1, 1'b0);
    quiet("lw_D", ST_D);
    exec_alu("lw_E", 3'b000, 1'b1, 2'b01);
    for (int i = 0; i < 3; i++)
      cyc("lw_Mwait", 1'b1, 1'b0, 1'b0, ST_M, MRD, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("lw_M", 1'b1, 1'b1, 1'b0, ST_M, MRD, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    wb("lw_W", 2'b00, 2'b01);

    bus.instr = I_SW;
    fetch("sw_F", 1'b1, 1'b1);
    quiet("sw_D", ST_D);
    exec_alu("sw_E", 3'b000, 1'b1, 2'b01);
    cyc("sw_Mwait", 1'b1, 1'b0, 1'b0, ST_M, MWR, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("sw_M", 1'b1, 1'b1, 1'b0, ST_M, MWR, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    // reset lands while a store is waiting in MEM
    fetch("sw2_F", 1'b1, 1'b1);
    quiet("sw2_D", ST_D);
    exec_alu("sw2_E", 3'b000, 1'b1, 2'b01);
    cyc("sw2_Mwait", 1'b1, 1'b0, 1'b0, ST_M, MWR, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("sw2_rst", 1'b0, 1'b1, 1'b0, ST_M, 5'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    bus.instr = I_BEQ;
    fetch("beq0_F", 1'b1, 1'b0);
    quiet("beq0_D", ST_D);
    cyc("beq0_E", 1'b1, 1'b1, 1'b0, ST_E, 5'b0, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    fetch("beq1_F", 1'b1, 1'b1);
    quiet("beq1_D", ST_D);
    cyc("beq1_E", 1'b1, 1'b1, 1'b1, ST_E, PCW, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    bus.instr = I_BNE;
    fetch("bne1_F", 1'b1, 1'b1);
    quiet("bne1_D", ST_D);
    cyc("bne1_E", 1'b1, 1'b1, 1'b1, ST_E, 5'b0, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    fetch("bne0_F", 1'b1, 1'b1);
    quiet("bne0_D", ST_D);
    cyc("bne0_E", 1'b1, 1'b1, 1'b0, ST_E, PCW, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    bus.instr = I_JR;
    fetch("jr_F", 1'b1, 1'b1);
    quiet("jr_D", ST_D);
    cyc("jr_E", 1'b1, 1'b1, 1'b0, ST_E, PCW, 2'b11, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    bus.instr = I_J;
    fetch("j_F", 1'b1, 1'b1);
    cyc("j_D", 1'b1, 1'b1, 1'b0, ST_D, PCW, 2'b10, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);

    bus.instr = I_JAL;
    fetch("jal_F", 1'b1, 1'b1);
    cyc("jal_D", 1'b1, 1'b1, 1'b0, ST_D, PCW | RGW, 2'b10, 3'b000, 1'b0, 2'b00, 2'b10, 2'b10, 1'b0);

    bus.instr = I_NOP;
    fetch("nop_F", 1'b1, 1'b1);
    quiet("nop_D", ST_D);

    bus.instr = I_ILL;
    fetch("ill_F", 1'b1, 1'b1);
    quiet("ill_D", ST_D);
    for (int i = 0; i < 10; i++)
      cyc("trap_hold", 1'b1, 1'(i % 2), 1'b1, ST_T, 5'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("trap_rst", 1'b0, 1'b1, 1'b0, ST_T, 5'b0, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    fetch("post_rst_F", 1'b1, 1'b0);

    for (int i = 0; i < 200 && !sat_done; i++) @(posedge clk);
    @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_seen; i++) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1: 1 = FETCH/MEM states wait for mem_ready; 0 = memory treated as ready every cycle.
REQ-002 Parameter CNT_W, default 32: width of the cycle and retired-instruction counters.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-low; sampled on the clk rising edge.
REQ-005 instr  in  32  IR contents; valid from DECODE onward, ignored in FETCH.
REQ-006 mem_ready  in  1  memory access complete this cycle.
REQ-007 zero  in  1  ALU result equals zero; sampled in EXEC.
REQ-008 pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath strobes.
REQ-009 pc_src  out  2  00 PC+4, 01 branch target, 10 jump index, 11 GPR[rs].
REQ-010 alu_op  out  3  000 add, 001 sub, 010 or, 011 lui-shift.
REQ-011 alu_src, ext_op  out  1, 2  ALU B select (0 reg, 1 ext imm); ext 00 zero, 01 sign, 10 upper.
REQ-012 reg_dst, wd_sel  out  2, 2  dest 00 rt, 01 rd, 10 r31; write data 00 ALU, 01 mem, 10 PC.
REQ-013 state  out  3  current state encoding; trap  out  1; instr_done  out  1.
REQ-014 cycle_cnt, instr_cnt  out  CNT_W  performance counters.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; all strobes are Moore/decode outputs of state plus instr, deasserted (0) unless listed.
REQ-016 FETCH: mem_read=1; on mem_ready (or always if MEM_HANDSHAKE=0): ir_write=1, pc_write=1, pc_src=00, next DECODE; otherwise remain in FETCH.
REQ-017 DECODE: instr==0 (nop) -> FETCH; j -> pc_write=1, pc_src=10 -> FETCH; jal -> additionally reg_write=1, reg_dst=10, wd_sel=10 -> FETCH; illegal op/func -> TRAP; all others -> EXEC.
REQ-018 Legal set: R-type func addu 100001, subu 100011, jr 001000; op ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
REQ-019 EXEC: addu/subu/ori/lui set alu_op/alu_src/ext_op -> WB; lw/sw: alu_op=000, alu_src=1, ext_op=01 -> MEM; beq: pc_write=zero, bne: pc_write=!zero, pc_src=01 -> FETCH; jr: pc_write=1, pc_src=11 -> FETCH.
REQ-020 MEM: lw mem_read=1, sw mem_write=1, held until mem_ready; lw -> WB, sw -> FETCH on mem_ready.
REQ-021 WB: reg_write=1; reg_dst=01 for R-type, 00 for ori/lui/lw; wd_sel=01 for lw else 00 -> FETCH.
REQ-022 TRAP: trap=1, all strobes 0, no exit except reset.
REQ-023 instr_done SHALL pulse 1 cycle on every transition into FETCH from a non-FETCH state.
REQ-024 cycle_cnt increments every non-reset cycle; instr_cnt increments on instr_done; both saturate at all-ones (no wrap).
REQ-025 Untaken branch still retires (instr_done=1, instr_cnt+1) with pc_write=0.

Reset
REQ-026 reset=0 at an edge: state=FETCH, counters=0, trap=0, instr_done=0, regardless of current state, including mid-MEM with mem_write asserted.
REQ-027 Strobes SHALL be 0 while reset=0 is being applied, except mem_read, which follows FETCH decode on the first cycle after release.

Structure
REQ-028 Package mc_pkg SHALL hold the state encoding, opcode/func constants, and pc_src/alu_op/ext_op/reg_dst/wd_sel codes.
REQ-029 Sub-module mc_decode: combinational op/func -> instruction class plus illegal flag; FSM and counters stay in mc_ctrl.

Verification
REQ-030 addu $3,$1,$2 (0x00221821), mem_ready=1: states 0,1,2,4,0; reg_write=1, reg_dst=01 in WB; instr_cnt=1.
REQ-031 lw with mem_ready low 3 cycles in MEM: mem_read held 3+1 cycles, then WB with wd_sel=01; total 8 cycles.
REQ-032 beq with zero=0 then zero=1: pc_write 0 then 1 in EXEC, pc_src=01; instr_cnt increments both times.
REQ-033 jal 0x0C000010: DECODE pc_write=1, pc_src=10, reg_write=1, reg_dst=10 -> FETCH; 2 cycles total.
REQ-034 Illegal op 0x3F: TRAP after DECODE, trap=1 held 10 cycles; reset=0 returns state=0, counters=0.
REQ-035 CNT_W=4, 20 nops with MEM_HANDSHAKE=0: cycle_cnt saturates at 15, instr_cnt at 15.
